// File: rtl/hebbian_weight_writer.sv
// Hebbian trainer: collects bipolar patterns from a serial bit stream, then streams
// the zero-diagonal outer-product weight matrix out row-major as Q(DATA_W-FRAC_W).FRAC_W words.
module hebbian_weight_writer #(
    parameter int NEURONS      = 25,
    parameter int MAX_PATTERNS = 4,
    parameter int DATA_W       = 16,
    parameter int FRAC_W       = 8,
    parameter int ADDR_W       = 10,
    localparam int CNT_W       = $clog2(MAX_PATTERNS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              pat_bit,
    input  logic              pat_valid,
    output logic              pat_ready,
    input  logic              train_start,
    output logic [ADDR_W-1:0] w_addr,
    output logic [DATA_W-1:0] w_data,
    output logic              w_we,
    input  logic              w_ready,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pat_count
);

    localparam int ELEM_W    = $clog2(NEURONS);
    localparam int IDX_W     = (MAX_PATTERNS > 1) ? $clog2(MAX_PATTERNS) : 1;
    localparam int LAST_ADDR = NEURONS * NEURONS - 1;
    localparam logic signed [DATA_W-1:0] ONE = 1;

    typedef enum logic {LOAD, GEN} state_t;

    state_t              state;
    state_t              state_next;
    logic                start_gen;
    logic                finish_gen;
    logic                accept_bit;
    logic                advance;
    logic [ELEM_W-1:0]   elem;
    logic [ELEM_W-1:0]   row;
    logic [ELEM_W-1:0]   col;
    logic [ELEM_W-1:0]   next_row;
    logic [ELEM_W-1:0]   next_col;
    logic signed [DATA_W-1:0] acc;
    logic [DATA_W-1:0]   next_weight;
    logic [NEURONS-1:0]  store [MAX_PATTERNS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= LOAD;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        start_gen  = 1'b0;
        finish_gen = 1'b0;
        case (state)
            LOAD: if (train_start) begin
                state_next = GEN;
                start_gen  = 1'b1;
            end
            GEN: if (w_ready && w_addr == ADDR_W'(LAST_ADDR)) begin
                state_next = LOAD;
                finish_gen = 1'b1;
            end
            default: state_next = LOAD;
        endcase
    end

    assign w_we       = (state == GEN);
    assign busy       = (state == GEN);
    assign pat_ready  = (state == LOAD) && (pat_count < CNT_W'(MAX_PATTERNS));
    // train_start and clear take precedence over a bit offered in the same cycle
    assign accept_bit = pat_valid && pat_ready && !train_start && !clear;
    assign advance    = (state == GEN) && w_ready && !finish_gen;

    always_comb begin
        next_row = row;
        next_col = col;
        if (start_gen) begin
            next_row = '0;
            next_col = '0;
        end else if (col == ELEM_W'(NEURONS - 1)) begin
            next_row = row + ELEM_W'(1);
            next_col = '0;
        end else begin
            next_col = col + ELEM_W'(1);
        end
    end

    // Agreement between the two elements contributes +1, disagreement -1.
    always_comb begin
        acc = '0;
        for (int p = 0; p < MAX_PATTERNS; p++) begin
            if (CNT_W'(p) < pat_count)
                acc = (store[p][next_row] == store[p][next_col]) ? acc + ONE : acc - ONE;
        end
        next_weight = (next_row == next_col) ? '0 : DATA_W'(acc <<< FRAC_W);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            elem      <= '0;
            pat_count <= '0;
            row       <= '0;
            col       <= '0;
            w_addr    <= '0;
            w_data    <= '0;
            done      <= 1'b0;
            for (int p = 0; p < MAX_PATTERNS; p++) store[p] <= '0;
        end else begin
            done <= finish_gen;
            if (state == LOAD) begin
                if (clear) begin
                    pat_count <= '0;
                    elem      <= '0;
                end else if (train_start) begin
                    elem <= '0;
                end else if (accept_bit) begin
                    store[pat_count[IDX_W-1:0]][elem] <= pat_bit;
                    if (elem == ELEM_W'(NEURONS - 1)) begin
                        elem      <= '0;
                        pat_count <= pat_count + CNT_W'(1);
                    end else begin
                        elem <= elem + ELEM_W'(1);
                    end
                end
            end
            if (start_gen || advance) begin
                row    <= next_row;
                col    <= next_col;
                w_data <= next_weight;
                w_addr <= start_gen ? '0 : w_addr + ADDR_W'(1);
            end else if (finish_gen) begin
                row    <= '0;
                col    <= '0;
                w_addr <= '0;
                w_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_hebbian_weight_writer.sv
// Randomized scoreboard bench for hebbian_weight_writer: a pattern-list model predicts
// every weight write; a negedge monitor pops and compares each accepted write.
module tb_hebbian_weight_writer;

    localparam int N  = 25;
    localparam int NN = N * N;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clear = 1'b0;
    logic       pat_bit = 1'b0;
    logic       pat_valid = 1'b0;
    logic       train_start = 1'b0;
    logic       w_ready = 1'b0;
    logic       pat_ready;
    logic [9:0] w_addr;
    logic [15:0] w_data;
    logic       w_we;
    logic       busy;
    logic       done;
    logic [2:0] pat_count;

    hebbian_weight_writer dut (
        .clk(clk), .rst(rst), .clear(clear), .pat_bit(pat_bit), .pat_valid(pat_valid),
        .pat_ready(pat_ready), .train_start(train_start), .w_addr(w_addr), .w_data(w_data),
        .w_we(w_we), .w_ready(w_ready), .busy(busy), .done(done), .pat_count(pat_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [25:0] exp_q[$];
    logic [N-1:0] mpats[$];
    logic [N-1:0] mcur = '0;
    int melem = 0;
    bit bp_mode = 1'b0;
    int done_cnt = 0;
    int gen_acc = 0;
    bit stalled = 1'b0;
    logic [25:0] held = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_w(input int i, input int j);
        int s;
        int xi;
        int xj;
        s = 0;
        if (i == j) return 16'h0000;
        foreach (mpats[p]) begin
            xi = mpats[p][i] ? 1 : -1;
            xj = mpats[p][j] ? 1 : -1;
            s += xi * xj;
        end
        return 16'(s * 256);
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            w_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        logic [25:0] e;
        forever begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                check("done_after_last", exp_q.size(), 0);
            end
            if (w_we) begin
                if (stalled) check("hold_stable", {w_addr, w_data}, held);
                if (w_ready) begin
                    stalled = 1'b0;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL extra_write: got addr 0x%0h, expected no write", w_addr);
                    end else begin
                        e = exp_q.pop_front();
                        check("w_addr", w_addr, e[25:16]);
                        check("w_data", w_data, e[15:0]);
                        gen_acc++;
                    end
                end else begin
                    stalled = 1'b1;
                    held = {w_addr, w_data};
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    task automatic send_bit(input logic b);
        bit room;
        pat_bit = b;
        pat_valid = 1'b1;
        room = (mpats.size() < 4);
        @(negedge clk);
        check("pat_ready", pat_ready, room);
        @(posedge clk);
        #1;
        pat_valid = 1'b0;
        if (room) begin
            mcur[melem] = b;
            melem++;
            if (melem == N) begin
                mpats.push_back(mcur);
                melem = 0;
            end
        end
    endtask

    task automatic load_pattern(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) send_bit(v[k]);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        mpats.delete();
        melem = 0;
    endtask

    task automatic run_gen(input bit bp, input int abort_at);
        bp_mode = bp;
        melem = 0;
        done_cnt = 0;
        gen_acc = 0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                exp_q.push_back({10'(i * N + j), model_w(i, j)});
        train_start = 1'b1;
        @(posedge clk);
        #1;
        train_start = 1'b0;
        pat_valid = 1'b1;
        @(negedge clk);
        check("busy_gen", busy, 1);
        check("pat_ready_gen", pat_ready, 0);
        for (int c = 0; c < 20; c++) begin
            pat_bit = 1'($urandom);
            @(posedge clk);
            #1;
        end
        pat_valid = 1'b0;
        if (abort_at > 0) begin
            for (int c = 0; c < 5000 && gen_acc < abort_at; c++) begin
                @(negedge clk);
                #1;
            end
            check("abort_reached", gen_acc, abort_at);
            rst = 1'b0;
            #1;
            check("rst_w_we", w_we, 0);
            check("rst_busy", busy, 0);
            check("rst_w_addr", w_addr, 0);
            check("rst_w_data", w_data, 0);
            check("rst_done", done, 0);
            exp_q.delete();
            mpats.delete();
            melem = 0;
            repeat (3) @(negedge clk);
            rst = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            check("post_rst_pat_ready", pat_ready, 1);
            check("post_rst_pat_count", pat_count, 0);
            check("post_rst_no_done", done_cnt, 0);
        end else begin
            for (int c = 0; c < 5000 && done_cnt == 0; c++) @(posedge clk);
            repeat (3) @(posedge clk);
            #1;
            check("done_once", done_cnt, 1);
            check("writes_remaining", exp_q.size(), 0);
            check("busy_after", busy, 0);
            check("w_we_after", w_we, 0);
            check("pat_count_after", pat_count, mpats.size());
            exp_q.delete();
        end
        bp_mode = 1'b0;
    endtask

    initial begin
        logic [N-1:0] alt;
        for (int k = 0; k < N; k++) alt[k] = (k % 2 == 0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_pat_ready", pat_ready, 1);
        check("reset_w_we", w_we, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_pat_count", pat_count, 0);
        check("reset_w_addr", w_addr, 0);
        check("reset_w_data", w_data, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        load_pattern('1);
        run_gen(1'b0, 0);

        do_clear();
        load_pattern('1);
        load_pattern(alt);
        run_gen(1'b0, 0);

        do_clear();
        repeat (4) load_pattern('1);
        send_bit(1'b1);
        check("full_pat_count", pat_count, 4);
        run_gen(1'b1, 0);
        run_gen(1'b1, 0);

        do_clear();
        load_pattern(N'($urandom));
        for (int k = 0; k < 10; k++) send_bit(1'($urandom));
        run_gen(1'b1, 0);
        do_clear();
        run_gen(1'b0, 0);

        load_pattern(N'($urandom));
        load_pattern(N'($urandom));
        run_gen(1'b1, 300);

        for (int k = 0; k < 3; k++) load_pattern(N'($urandom));
        run_gen(1'b1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
